// File: rtl/store_pkg.sv
// store_pkg: store size encodings and store-merge FSM state encoding
package store_pkg;
  localparam logic [1:0] SZ_SW  = 2'b00;
  localparam logic [1:0] SZ_SH  = 2'b01;
  localparam logic [1:0] SZ_SB  = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge: replace the little-endian byte lanes selected by size/lane with new data
module store_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);
  logic [3:0]  be;
  logic [31:0] rep;
  assign be  = size == SZ_SW ? 4'hf : size == SZ_SH ? (lane[1] ? 4'hc : 4'h3) : 4'h1 << lane;
  assign rep = size == SZ_SW ? new_data : size == SZ_SH ? {2{new_data[15:0]}} : {4{new_data[7:0]}};
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = be[i] ? rep[8*i +: 8] : old_word[8*i +: 8];
  end
endmodule

// File: rtl/store_merge_unit.sv
// store_merge_unit: SW/SH/SB store path with read-modify-write for partial stores (STORE_ALIGN_CHECK_EN rejects odd SH)
module store_merge_unit
  import store_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic              busy,
  output logic              done,
  output logic              misalign
);
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  state_t            state, state_nx;
  logic [1:0]        sz, lane;
  logic [DATA_W-1:0] data, merged;
  logic [CW-1:0]     cnt;
  logic              err, bad;
`ifdef STORE_ALIGN_CHECK_EN
  assign bad = size == SZ_RSV || (size == SZ_SH && addr[0]);
`else
  assign bad = size == SZ_RSV;
`endif
  store_lane_merge u_merge (
    .old_word (mem_rdata),
    .new_data (data),
    .size     (sz),
    .lane     (lane),
    .merged   (merged)
  );
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= state_nx;
  // next-state decode and status outputs
  always_comb begin
    state_nx = state == S_IDLE  ? (start ? (bad ? S_DONE : size == SZ_SW ? S_WRITE : S_READ) : S_IDLE)
             : state == S_READ  ? (cnt == CW'(MEM_LAT - 1) ? S_MERGE : S_READ)
             : state == S_MERGE ? S_WRITE
             : state == S_WRITE ? S_DONE
             : S_IDLE;
    busy     = state != S_IDLE;
    done     = state == S_DONE;
    misalign = done & err;
  end
  // request capture, read-latency counter, merged word and write strobe
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
      sz        <= SZ_SW;
      lane      <= 2'b00;
      data      <= '0;
      err       <= 1'b0;
      cnt       <= '0;
    end else begin
      mem_wr <= state_nx == S_WRITE;
      cnt    <= state == S_READ ? cnt + 1'b1 : '0;
      if (state == S_IDLE && start) begin
        sz        <= size;
        lane      <= addr[1:0];
        data      <= store_data;
        err       <= bad;
        mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
        mem_wdata <= store_data;
      end
      if (state == S_MERGE) mem_wdata <= merged;
    end
endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: table-driven, directed-sequence and random checks of store_merge_unit
module tb_store_merge_unit;
  localparam int MEM_LAT = 2;
`ifdef STORE_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 0, reset = 0, start = 0;
  logic [1:0]  size = 0;
  logic [31:0] addr = 0, store_data = 0, mem_rdata, mem_addr, mem_wdata;
  logic mem_wr, busy, done, misalign;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] pipe [MEM_LAT];
  logic ld = 0;
  logic [5:0] ld_idx = 0;
  logic [31:0] ld_val = 0;
  int wr_cnt = 0;
  int total = 0, bad = 0;

  store_merge_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr),
    .store_data(store_data), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wr(mem_wr), .busy(busy), .done(done), .misalign(misalign)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld) mem[ld_idx] <= ld_val;
    if (mem_wr) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    pipe[0] <= mem[mem_addr[7:2]];
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[MEM_LAT-1];

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] a, d, pre, exp_word;
    logic        exp_mis;
  } vec_t;
  vec_t tv [9];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    ld = 1; ld_idx = a[7:2]; ld_val = v;
    @(posedge clk); #1 ld = 0;
    ref_mem[a[7:2]] = v;
  endtask

  function automatic logic is_bad(input logic [1:0] sz, input logic [31:0] a);
    return sz == 2'b11 || (ALIGN && sz == 2'b01 && a[0]);
  endfunction

  function automatic logic [31:0] model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input logic [31:0] old);
    int sh;
    if (is_bad(sz, a)) return old;
    if (sz == 2'b00) return d;
    if (sz == 2'b01) begin
      sh = a[1] ? 16 : 0;
      return (old & ~(32'hffff << sh)) | ((d & 32'hffff) << sh);
    end
    sh = 8 * int'(a[1:0]);
    return (old & ~(32'hff << sh)) | ((d & 32'hff) << sh);
  endfunction

  task automatic run_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_word, input logic exp_mis);
    int wr_at, done_at, wrs, exp_done, exp_wr;
    logic mis;
    logic [31:0] wd, wa;
    wr_at = -1; done_at = -1; wrs = 0; mis = 0; wd = 0; wa = 0;
    exp_done = is_bad(sz, a) ? 1 : sz == 2'b00 ? 2 : MEM_LAT + 3;
    exp_wr   = is_bad(sz, a) ? -1 : exp_done - 1;
    @(negedge clk);
    size = sz; addr = a; store_data = d; start = 1;
    @(posedge clk); #1 start = 0;
    for (int n = 1; n <= 16 && done_at < 0; n++) begin
      if (mem_wr) begin wrs++; wr_at = n; wd = mem_wdata; wa = mem_addr; end
      if (done) begin done_at = n; mis = misalign; end
      @(posedge clk); #1;
    end
    chk("done_latency", 96'(done_at), 96'(exp_done));
    chk("misalign", 96'(mis), 96'(exp_mis));
    chk("write_count", 96'(wrs), is_bad(sz, a) ? 96'd0 : 96'd1);
    if (!is_bad(sz, a)) begin
      chk("write_latency", 96'(wr_at), 96'(exp_wr));
      chk("write_addr", 96'(wa), 96'(a & ~32'h3));
      chk("write_data", 96'(wd), 96'(exp_word));
    end
    chk("mem_word", 96'(mem[a[7:2]]), 96'(exp_word));
    ref_mem[a[7:2]] = exp_word;
  endtask

  initial begin
    int w0, got;
    logic [1:0] sz;
    logic [31:0] a, d;
    tv[0] = '{2'b00, 32'h10, 32'hdeadbeef, 32'h0,        32'hdeadbeef, 1'b0};
    tv[1] = '{2'b10, 32'h13, 32'h000000aa, 32'h11223344, 32'haa223344, 1'b0};
    tv[2] = '{2'b01, 32'h22, 32'h0000beef, 32'h11223344, 32'hbeef3344, 1'b0};
    tv[3] = '{2'b01, 32'h21, 32'h0000beef, 32'h11223344, ALIGN ? 32'h11223344 : 32'h1122beef, ALIGN};
    tv[4] = '{2'b11, 32'h30, 32'h12345678, 32'h55555555, 32'h55555555, 1'b1};
    tv[5] = '{2'b10, 32'h34, 32'hffffff01, 32'h0,        32'h00000001, 1'b0};
    tv[6] = '{2'b10, 32'h35, 32'h00000077, 32'hcafebabe, 32'hcafe77be, 1'b0};
    tv[7] = '{2'b01, 32'h38, 32'h1234abcd, 32'hffffffff, 32'hffffabcd, 1'b0};
    tv[8] = '{2'b00, 32'h3f, 32'h01020304, 32'h0,        32'h01020304, 1'b0};
    for (int i = 0; i < MEM_LAT; i++) pipe[i] = 0;
    #2;
    chk("reset_outputs", {mem_addr, mem_wdata, mem_wr, busy, done, misalign}, 96'd0);
    @(negedge clk); reset = 1;
    for (int i = 0; i < 64; i++) preload(32'(i * 4), 32'(i) * 32'h01010101);
    for (int i = 0; i < 9; i++) begin
      preload(tv[i].a, tv[i].pre);
      run_store(tv[i].sz, tv[i].a, tv[i].d, tv[i].exp_word, tv[i].exp_mis);
    end
    // start while busy is ignored, including a start held through the DONE cycle
    preload(32'h40, 32'h01020304);
    preload(32'h44, 32'h99999999);
    w0 = wr_cnt;
    got = 0;
    @(negedge clk); size = 2'b10; addr = 32'h41; store_data = 32'hee; start = 1;
    @(posedge clk); #1;
    @(negedge clk); size = 2'b00; addr = 32'h44; store_data = 32'h0;
    for (int n = 0; n < 20 && got == 0; n++) begin
      @(posedge clk); #1;
      if (done) got = 1;
    end
    @(negedge clk); start = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_start_done", 96'(got), 96'd1);
    chk("busy_start_writes", 96'(wr_cnt - w0), 96'd1);
    chk("busy_start_target", 96'(mem[6'h10]), 96'h0102ee04);
    chk("busy_start_other", 96'(mem[6'h11]), 96'h99999999);
    chk("busy_start_idle", 96'(busy), 96'd0);
    ref_mem[6'h10] = 32'h0102ee04;
    // reset while reading
    preload(32'h50, 32'ha5a5a5a5);
    w0 = wr_cnt;
    @(negedge clk); size = 2'b10; addr = 32'h50; store_data = 32'h11; start = 1;
    @(posedge clk); #1 start = 0;
    chk("read_busy", 96'(busy), 96'd1);
    #2 reset = 0;
    #1 chk("reset_in_read", {mem_addr, mem_wdata, mem_wr, busy, done, misalign}, 96'd0);
    @(negedge clk); reset = 1;
    repeat (8) @(posedge clk);
    #1;
    chk("reset_read_nowrite", 96'(wr_cnt - w0), 96'd0);
    chk("reset_read_mem", 96'(mem[6'h14]), 96'ha5a5a5a5);
    // reset while writing
    preload(32'h54, 32'h0);
    w0 = wr_cnt;
    @(negedge clk); size = 2'b00; addr = 32'h54; store_data = 32'h12345678; start = 1;
    @(posedge clk); #1 start = 0;
    chk("write_strobe", 96'(mem_wr), 96'd1);
    reset = 0;
    #1 chk("reset_in_write", {mem_addr, mem_wdata, mem_wr, busy, done, misalign}, 96'd0);
    @(negedge clk); reset = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("reset_write_nowrite", 96'(wr_cnt - w0), 96'd0);
    chk("reset_write_mem", 96'(mem[6'h15]), 96'd0);
    // random stores against the reference model
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 255));
      d = $urandom;
      run_store(sz, a, d, model(sz, a, d, ref_mem[a[7:2]]), is_bad(sz, a));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
